nonce_result_writer: RTL
========================

Name: nonce_result_writer

Overview:
Downstream stage of the parallel SHA-256 lanes. Captures the final H0 word of every nonce lane in one cycle, then drains the words serially into the shared memory at consecutive addresses from output_addr. Writes only in cycles where the top-level arbiter grants the memory port. Pulses done when the last word is committed.

Parameters:
NUM_NONCES, 16, number of parallel nonce lanes and words written per capture
ADDR_W, 16, memory address width
DATA_W, 32, memory/word width

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous active-low reset
cap_valid  input  1  hout_bus holds final H0 of all lanes (COMPUTE3 complete)
cap_ready  output  1  writer idle and able to accept a capture
hout_bus  input  NUM_NONCES*DATA_W  lane i H0 at bits [i*DATA_W +: DATA_W]
output_addr  input  ADDR_W  base address, sampled at capture
mem_gnt  input  1  memory port granted to writer this cycle
mem_we  output  1  write strobe
mem_addr  output  ADDR_W  write address
mem_write_data  output  DATA_W  write data
done  output  1  one-cycle pulse after last write

Behaviour:
- States: IDLE, WRITE, DONE (2-bit encoding).
- Reset (async, reset_n=0): state=IDLE, idx=0, base=0, buffer cleared; cap_ready=1, mem_we=0, mem_addr=0, mem_write_data=0, done=0. Reset mid-WRITE aborts immediately; no further writes and no done pulse.
- IDLE: cap_ready=1. On cap_valid=1 at an edge: latch all NUM_NONCES words, base<=output_addr, idx<=0, go to WRITE.
- WRITE: cap_ready=0. Combinational outputs: mem_we=mem_gnt, mem_addr=base+idx (mod 2^ADDR_W, wraps silently), mem_write_data=buf[idx].
- WRITE, mem_gnt=1 at edge: the write commits. If idx==NUM_NONCES-1, go to DONE; otherwise idx<=idx+1.
- WRITE, mem_gnt=0: hold idx and outputs. mem_we=0. No timeout.
- DONE: done=1 for exactly one cycle, mem_we=0, cap_ready=0, then go to IDLE.
- Outside WRITE: mem_addr/mem_write_data are 0 (no stale data on bus).
- cap_valid while not IDLE is ignored. The producer holds cap_valid until it sees cap_ready.
- Latency with mem_gnt held high: capture at edge k; writes at edges k+1 through k+NUM_NONCES; done high in cycle after edge k+NUM_NONCES; cap_ready returns after edge k+NUM_NONCES+1.
- idx width is $clog2(NUM_NONCES), minimum 1 bit. NUM_NONCES=1 is legal: one write, then DONE.
- Buffer is not shifted; it is indexed by idx, and only loaded at capture.

Decomposition:
- Shared package bitcoin_pkg: NUM_NONCES default, word_t (logic [31:0]), writer_state_t enum {IDLE, WRITE, DONE}. The pblock/bitcoin_hash top reuse the same package.
- No sub-module. The word buffer and address counter are small enough to stay inline.

Test Plan:
- Basic: lane i word = 32'hA0000000+i, output_addr=16'h0100, mem_gnt=1 -> 16 writes, addr 0x0100..0x010F, data A0000000..A000000F in order; done pulses once, one cycle after the 16th write.
- Grant stalls: mem_gnt low on alternating cycles -> no write when gnt=0; addr/data held; same 16 (addr,data) pairs, no duplicates; done after the 16th granted cycle.
- Busy capture: second cap_valid with different data while in WRITE -> ignored (cap_ready=0); memory contents match the first capture only.
- Wrap: output_addr=16'hFFF8 -> writes to FFF8..FFFF then 0000..0007.
- Reset mid-op: reset_n low after 5 writes -> mem_we drops immediately, no done pulse; new capture after release writes all 16 words from base again.
- Back-to-back: cap_valid held high continuously -> second capture accepted in the first cycle cap_ready=1 after DONE; two clean 16-write bursts, done pulses twice.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared types for the bitcoin hashing datapath: lane count, word type and
// the result-writer state encoding.
package bitcoin_pkg;

  localparam int unsigned NUM_NONCES_DEFAULT = 16;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/nonce_result_writer_if.sv
// Capture handshake and memory write port of the nonce result writer.
// master = producer/arbiter side, slave = writer side.
interface nonce_result_writer_if #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32
);

  logic                         cap_valid;
  logic                         cap_ready;
  logic [NUM_NONCES*DATA_W-1:0] hout_bus;
  logic [ADDR_W-1:0]            output_addr;
  logic                         mem_gnt;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_write_data;
  logic                         done;

  modport master (
    output cap_valid, hout_bus, output_addr, mem_gnt,
    input  cap_ready, mem_we, mem_addr, mem_write_data, done
  );

  modport slave (
    input  cap_valid, hout_bus, output_addr, mem_gnt,
    output cap_ready, mem_we, mem_addr, mem_write_data, done
  );

endinterface

// File: rtl/nonce_result_writer.sv
// Captures the final H0 of every nonce lane at once, then drains the words to
// memory at base, base+1, ... only in cycles the arbiter grants the port.
module nonce_result_writer
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  nonce_result_writer_if.slave  bus_io
);

  localparam int unsigned IdxW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

  writer_state_t     state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] buf_q [NUM_NONCES];
  logic [DATA_W-1:0] buf_d [NUM_NONCES];
  logic              last_idx;

  assign last_idx = (idx_q == IdxW'(NUM_NONCES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (bus_io.cap_valid) begin
          for (int unsigned i = 0; i < NUM_NONCES; i++) begin
            buf_d[i] = bus_io.hout_bus[i*DATA_W +: DATA_W];
          end
          base_d  = bus_io.output_addr;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Without a grant nothing moves; the same beat is re-presented.
        if (bus_io.mem_gnt) begin
          if (last_idx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      for (int unsigned i = 0; i < NUM_NONCES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
    end
  end

  // Bus is zeroed outside WRITE so no stale result leaks onto shared memory.
  assign bus_io.cap_ready      = (state_q == IDLE);
  assign bus_io.done           = (state_q == DONE);
  assign bus_io.mem_we         = (state_q == WRITE) && bus_io.mem_gnt;
  assign bus_io.mem_addr       = (state_q == WRITE) ? base_q + ADDR_W'(idx_q) : '0;
  assign bus_io.mem_write_data = (state_q == WRITE) ? buf_q[idx_q] : '0;

endmodule
